// File: rtl/ram2e_efb_model_if.sv
// ram2e_efb_model_if: Wishbone bundle between the host and the EFB model
interface ram2e_efb_model_if;
   logic wb_cyc_i, wb_stb_i, wb_we_i;
   logic [7:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic wb_ack_o, wbc_ufm_irq;
   modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, input wb_dat_o, wb_ack_o, wbc_ufm_irq);
   modport slave (input wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, output wb_dat_o, wb_ack_o, wbc_ufm_irq);
endinterface

// File: rtl/ram2e_efb_model.sv
// ram2e_efb_model: MachXO2 EFB configuration port model exposing one UFM page over Wishbone
module ram2e_efb_model #(
   parameter int unsigned PAGE_ADDR = 190,
   parameter logic [7:0] INIT0 = 8'h00,
   parameter logic [7:0] INIT1 = 8'h01
) (
   input logic C14M,
   input logic nRES,
   input logic wb_rst_i,
   ram2e_efb_model_if.slave wb
);
   typedef enum logic [1:0] {IDLE, CMD, OPER, DATA} state_t;
   state_t state;
   logic [7:0] cfgcr, opcode, rx, rdata;
   logic [1:0] opcnt, nops;
   logic [3:0] cnt;
   logic [13:0] page;
   logic cfg_en, xfer, wr, rd, hit;
   function automatic logic [1:0] ops_for(input logic [7:0] op);
      return (op == 8'h74 || op == 8'h3C || op == 8'hB4 || op == 8'hCA) ? 2'd3 : op == 8'h26 ? 2'd2 : 2'd0;
   endfunction
   function automatic logic en_for(input logic [7:0] op, input logic cur);
      return op == 8'h74 ? 1'b1 : (op == 8'h26 || op == 8'hFF) ? 1'b0 : cur;
   endfunction
   assign xfer = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
   assign wr = xfer & wb.wb_we_i;
   assign rd = xfer & ~wb.wb_we_i;
   assign nops = ops_for(wb.wb_dat_i);
   assign hit = cfg_en && page == 14'(PAGE_ADDR);
   assign wb.wbc_ufm_irq = 1'b0;
   // Only the low 14 address bits are kept: the upper bytes of the 32-bit shift never reach the page number
   always_comb begin
      rx = 8'h00;
      if (state == DATA && opcode == 8'h3C) rx = cnt == 4'd2 ? {6'b0, cfg_en, 1'b0} : 8'h00;
      else if (state == DATA && opcode == 8'hCA) rx = !hit ? 8'hFF : cnt == 4'd0 ? INIT0 : cnt == 4'd1 ? INIT1 : 8'h00;
   end
   assign rdata = wb.wb_adr_i == 8'h70 ? cfgcr : wb.wb_adr_i == 8'h73 ? rx : 8'h00;
   always_ff @(posedge C14M or negedge nRES) begin
      if (!nRES) begin
         wb.wb_ack_o <= 1'b0; wb.wb_dat_o <= 8'h00; state <= IDLE; cfgcr <= 8'h00; opcode <= 8'h00;
         opcnt <= 2'd0; cnt <= 4'd0; page <= 14'd0; cfg_en <= 1'b0;
      end else if (wb_rst_i) begin
         wb.wb_ack_o <= 1'b0; wb.wb_dat_o <= 8'h00; state <= IDLE; cfgcr <= 8'h00; opcode <= 8'h00;
         opcnt <= 2'd0; cnt <= 4'd0; page <= 14'd0; cfg_en <= 1'b0;
      end else begin
         wb.wb_ack_o <= xfer;
         if (rd) wb.wb_dat_o <= rdata;
         if (wr && wb.wb_adr_i == 8'h70) begin
            cfgcr <= wb.wb_dat_i;
            state <= wb.wb_dat_i[7] ? CMD : IDLE;
            if (wb.wb_dat_i[7]) begin opcnt <= 2'd0; cnt <= 4'd0; end
         end
         if (wr && wb.wb_adr_i == 8'h71)
            case (state)
               CMD: begin
                  opcode <= wb.wb_dat_i;
                  opcnt <= nops;
                  cnt <= 4'd0;
                  state <= nops == 2'd0 ? DATA : OPER;
                  if (nops == 2'd0) cfg_en <= en_for(wb.wb_dat_i, cfg_en);
               end
               OPER: begin
                  opcnt <= opcnt - 2'd1;
                  if (opcnt == 2'd1) begin state <= DATA; cnt <= 4'd0; cfg_en <= en_for(opcode, cfg_en); end
               end
               DATA: if (opcode == 8'hB4 && cnt < 4'd4) begin page <= {page[5:0], wb.wb_dat_i}; cnt <= cnt + 4'd1; end
               default: ;
            endcase
         if (rd && wb.wb_adr_i == 8'h73 && state == DATA) begin
            if (opcode == 8'h3C && cnt < 4'd4) cnt <= cnt + 4'd1;
            if (opcode == 8'hCA) begin cnt <= cnt + 4'd1; if (cnt == 4'hF) page <= page + 14'd1; end
         end
      end
   end
endmodule

// File: tb/tb_ram2e_efb_model.sv
// tb_ram2e_efb_model: directed boot sequences plus random Wishbone traffic against a transaction-level model
module tb_ram2e_efb_model;
   localparam logic [7:0] I0 = 8'hA5, I1 = 8'h01;
   logic clk = 1'b0, n_res = 1'b0, wb_rst = 1'b0;
   int checks = 0, errors = 0;
   logic [7:0] ops [6] = '{8'h74, 8'h3C, 8'hB4, 8'hCA, 8'h26, 8'hFF};
   ram2e_efb_model_if bus();
   ram2e_efb_model #(.PAGE_ADDR(190), .INIT0(I0), .INIT1(I1)) dut (.C14M(clk), .nRES(n_res), .wb_rst_i(wb_rst), .wb(bus));
   always #5 clk = ~clk;
   // Reference: frame phase 0 idle, 1 command, 2 operands, 3 data; 32-bit address register as seen by software
   int m_st, m_left, m_idx, m_reads;
   logic [7:0] m_cr, m_op;
   logic [31:0] m_addr;
   logic m_en;
   function automatic void m_reset();
      m_st = 0; m_left = 0; m_idx = 0; m_reads = 0; m_cr = 8'h00; m_op = 8'h00; m_addr = 32'h0; m_en = 1'b0;
   endfunction
   function automatic void m_enter_data();
      m_st = 3; m_idx = 0; m_reads = 0;
      if (m_op == 8'h74) m_en = 1'b1;
      else if (m_op == 8'h26 || m_op == 8'hFF) m_en = 1'b0;
   endfunction
   function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
      if (a == 8'h70) begin
         m_cr = d;
         m_st = d[7] ? 1 : 0;
      end else if (a == 8'h71) begin
         if (m_st == 1) begin
            m_op = d;
            m_left = (d inside {8'h74, 8'h3C, 8'hB4, 8'hCA}) ? 3 : d == 8'h26 ? 2 : 0;
            m_st = 2;
            if (m_left == 0) m_enter_data();
         end else if (m_st == 2) begin
            m_left--;
            if (m_left == 0) m_enter_data();
         end else if (m_st == 3 && m_op == 8'hB4 && m_idx < 4) begin
            m_addr = {m_addr[23:0], d};
            m_idx++;
         end
      end
   endfunction
   function automatic logic [7:0] m_read(input logic [7:0] a);
      logic [7:0] r;
      int n;
      r = 8'h00;
      if (a == 8'h70) r = m_cr;
      else if (a == 8'h73 && m_st == 3 && m_op == 8'h3C) begin
         r = m_reads == 2 ? {6'b0, m_en, 1'b0} : 8'h00;
         m_reads++;
      end else if (a == 8'h73 && m_st == 3 && m_op == 8'hCA) begin
         n = m_reads % 16;
         r = (m_en && m_addr[13:0] == 14'd190) ? (n == 0 ? I0 : n == 1 ? I1 : 8'h00) : 8'hFF;
         m_reads++;
         if (n == 15) m_addr[13:0] = m_addr[13:0] + 14'd1;
      end
      return r;
   endfunction
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic wb_io(input logic we, input logic [7:0] adr, input logic [7:0] dat, output logic [7:0] q);
      int n;
      n = 0;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = dat;
      do begin @(negedge clk); n++; end while (!bus.wb_ack_o && n < 8);
      check("ack_lat", 8'(n), 8'd1);
      q = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(negedge clk);
      check("ack_width", {7'b0, bus.wb_ack_o}, 8'h00);
   endtask
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      logic [7:0] q;
      wb_io(1'b1, a, d, q);
      m_write(a, d);
   endtask
   task automatic rd(input logic [7:0] a);
      logic [7:0] q, e;
      wb_io(1'b0, a, 8'h00, q);
      e = m_read(a);
      check($sformatf("rd_%h", a), q, e);
   endtask
   task automatic cmd(input logic [7:0] op, input int n);
      wr(8'h70, 8'h80);
      wr(8'h71, op);
      repeat (n) wr(8'h71, 8'h00);
   endtask
   task automatic b4_ca(input logic [7:0] last, input int reads);
      cmd(8'hB4, 3);
      wr(8'h71, 8'h40); wr(8'h71, 8'h00); wr(8'h71, 8'h00); wr(8'h71, last);
      wr(8'h70, 8'h00);
      wr(8'h70, 8'h80); wr(8'h71, 8'hCA); wr(8'h71, 8'h10); wr(8'h71, 8'h00); wr(8'h71, 8'h01);
      repeat (reads) rd(8'h73);
      wr(8'h70, 8'h00);
   endtask
   task automatic boot(input bit en, input logic [7:0] last);
      if (en) begin cmd(8'h74, 3); wr(8'h70, 8'h00); end
      cmd(8'h3C, 3);
      repeat (5) rd(8'h73);
      wr(8'h70, 8'h00);
      b4_ca(last, 16);
      cmd(8'h26, 2); wr(8'h70, 8'h00);
      cmd(8'hFF, 0); wr(8'h70, 8'h00);
   endtask
   task automatic held(input logic we, input logic [7:0] a, input logic [7:0] d);
      logic [7:0] e;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we; bus.wb_adr_i = a; bus.wb_dat_i = d;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("held_ack", {7'b0, bus.wb_ack_o}, (i % 2 == 0) ? 8'h01 : 8'h00);
         if (bus.wb_ack_o) begin
            if (we) m_write(a, d);
            else begin e = m_read(a); check("held_rd", bus.wb_dat_o, e); end
         end
      end
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      int r, s;
      logic [7:0] a, d, e;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_adr_i = 8'h00; bus.wb_dat_i = 8'h00;
      m_reset();
      #12;
      check("rst_ack", {7'b0, bus.wb_ack_o}, 8'h00);
      check("rst_dat", bus.wb_dat_o, 8'h00);
      check("irq", {7'b0, bus.wbc_ufm_irq}, 8'h00);
      @(negedge clk); n_res = 1'b1; @(negedge clk);
      rd(8'h70);
      held(1'b1, 8'h70, 8'h80);
      rd(8'h70);
      held(0, 8'h70, 8'h00);
      wr(8'h70, 8'h00);
      boot(1'b1, 8'hBE);
      boot(1'b0, 8'hBE);
      cmd(8'h74, 3); wr(8'h70, 8'h00);
      b4_ca(8'hBD, 32);
      wr(8'h70, 8'h80); wr(8'h71, 8'hCA); wr(8'h71, 8'h10); wr(8'h70, 8'h00);
      wr(8'h70, 8'h80); rd(8'h73); rd(8'h71); wr(8'h73, 8'h55);
      wr(8'h71, 8'h3C); wr(8'h71, 8'h00); wr(8'h71, 8'h00); wr(8'h71, 8'h00);
      repeat (4) rd(8'h73);
      rd(8'h72); rd(8'h70);
      wr(8'h70, 8'h80);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 8'h70; wb_rst = 1'b1;
      @(negedge clk);
      check("wbrst_ack", {7'b0, bus.wb_ack_o}, 8'h00);
      check("wbrst_dat", bus.wb_dat_o, 8'h00);
      wb_rst = 1'b0; m_reset();
      @(negedge clk);
      check("retry_ack", {7'b0, bus.wb_ack_o}, 8'h01);
      e = m_read(8'h70);
      check("retry_dat", bus.wb_dat_o, e);
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(negedge clk);
      cmd(8'h74, 3); wr(8'h70, 8'h00); wr(8'h70, 8'h80);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 8'h70;
      @(negedge clk);
      check("nres_pre_ack", {7'b0, bus.wb_ack_o}, 8'h01);
      check("nres_pre_dat", bus.wb_dat_o, m_cr);
      #2 n_res = 1'b0;
      #1 check("nres_ack", {7'b0, bus.wb_ack_o}, 8'h00);
      check("nres_dat", bus.wb_dat_o, 8'h00);
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      @(negedge clk); n_res = 1'b1; m_reset(); @(negedge clk);
      b4_ca(8'hBE, 16);
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 99);
         if (r < 10) wr(8'h70, 8'($urandom));
         else if (r < 45) begin
            s = $urandom_range(0, 3);
            d = s < 2 ? ops[$urandom_range(0, 5)] : s == 2 ? 8'hBE : 8'($urandom);
            wr(8'h71, d);
         end else if (r < 75) rd(8'h73);
         else if (r < 80) rd(8'h70);
         else if (r < 84) rd(8'h72);
         else if (r < 87) rd(8'h71);
         else if (r < 90) wr(8'h73, 8'($urandom));
         else if (r < 97) begin
            a = 8'($urandom);
            if (a inside {[8'h70:8'h73]}) a = 8'h10;
            if ($urandom_range(0, 1) == 1) rd(a);
            else wr(a, 8'($urandom));
         end else begin
            wb_rst = 1'b1; @(negedge clk); wb_rst = 1'b0; m_reset(); @(negedge clk);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram2e_efb_model.md
RAM2E_EFB_MODEL -- requirements
Module: ram2e_efb_model

Interface
REQ-001 Parameter PAGE_ADDR, default 190: UFM page address whose contents are modelled.
REQ-002 Parameter INIT0, default 8'h00: UFM byte 0 of modelled page (RWMask image).
REQ-003 Parameter INIT1, default 8'h01: UFM byte 1 of modelled page (LEDEN image); bytes 2-15 SHALL read 8'h00.
REQ-004 C14M  input  1  sole clock, all logic on rising edge.
REQ-005 nRES  input  1  reset, asynchronous, active-low.
REQ-006 wb_rst_i  input  1  Wishbone synchronous protocol reset, active-high.
REQ-007 wb_cyc_i, wb_stb_i  input  1 each  Wishbone cycle/strobe.
REQ-008 wb_we_i  input  1  1 = write, 0 = read.
REQ-009 wb_adr_i  input  8  EFB register address.
REQ-010 wb_dat_i  input  8  write data.
REQ-011 wb_dat_o  output  8  read data, registered, valid while wb_ack_o=1.
REQ-012 wb_ack_o  output  1  one-cycle acknowledge.
REQ-013 wbc_ufm_irq  output  1  UFM interrupt, constant 0.

Function
REQ-014 Handshake: wb_ack_o SHALL be registered as cyc&stb&~ack; ack rises exactly 1 cycle after cyc&stb sampled high, lasts 1 cycle; held strobe yields ack every other cycle, each ack one transfer.
REQ-015 All register side effects SHALL occur on the edge asserting wb_ack_o, once per acked transfer.
REQ-016 Addr 8'h70 (CFGCR): write stores byte; bit7 = frame open; write with bit7=1 SHALL enter CMD state and clear byte counter; write with bit7=0 SHALL enter IDLE; read returns stored byte.
REQ-017 Addr 8'h72 (CFGSR): read SHALL return 8'h00 (never busy, no errors).
REQ-018 Addr 8'h71 (CFGTXDR) write in IDLE SHALL be ignored (still acked).
REQ-019 CMD state: byte written to 8'h71 SHALL latch as opcode and enter OPER state with operand count 3 for 8'h74/8'h3C/8'hB4/8'hCA, 2 for 8'h26, 0 for 8'hFF/others (direct to DATA).
REQ-020 OPER state: each write to 8'h71 SHALL decrement operand count; at zero enter DATA with data counter 0; operand values ignored.
REQ-021 Opcode 8'h74 on entering DATA SHALL set cfg_en=1; 8'h26 and 8'hFF SHALL clear cfg_en.
REQ-022 Opcode 8'hB4 DATA: four writes to 8'h71 shift MSB-first into 32-bit address register; page address = bits[13:0]; writes beyond 4 ignored.
REQ-023 Addr 8'h73 (CFGRXDR) read in DATA with opcode 8'h3C SHALL return status bytes MSB first: 8'h00, 8'h00, {6'b0, cfg_en, 1'b0}, 8'h00; further reads 8'h00.
REQ-024 Addr 8'h73 read in DATA with opcode 8'hCA: byte n (n=0..15) = page byte n when cfg_en=1 and page address=PAGE_ADDR, else 8'hFF; after 16th read page address SHALL increment (14-bit wrap 3FFF->0000) and n wrap to 0.
REQ-025 Addr 8'h73 read in any other state/opcode SHALL return 8'h00; reads do not change state.
REQ-026 Unmapped addresses: reads return 8'h00, writes ignored, always acked.
REQ-027 Write to 8'h73 or read of 8'h71 SHALL have no side effect; read of 8'h71 returns 8'h00.
REQ-028 Frame close (8'h70 bit7=0) mid-operand or mid-data SHALL abort to IDLE; cfg_en and page address retained.
REQ-029 New frame open while already in a frame SHALL restart at CMD.

Reset
REQ-030 nRES=0 asynchronously: wb_ack_o=0, wb_dat_o=8'h00, state IDLE, CFGCR=8'h00, cfg_en=0, page address=0, all counters 0.
REQ-031 wb_rst_i=1 at a clock edge: same values as REQ-030, and no ack generated that cycle; takes priority over a pending transfer.
REQ-032 Reset asserted mid-transfer SHALL drop ack; the initiator retry after reset is a fresh transfer.

Verification
REQ-033 Held cyc/stb write 8'h80 to 8'h70 -> ack 1 cycle later, 1 cycle wide; read 8'h70 -> 8'h80.
REQ-034 Full boot sequence (74+3 ops, 3C+3 ops + 4 reads, B4+3 ops + data 40,00,00,BE, CA+ops 10,00,01, 16 reads, 26, FF) with INIT0=8'hA5 -> status byte 2 = 8'h02; reads A5, 01, then 14x 00.
REQ-035 Same sequence omitting 8'h74 -> all 16 CA reads 8'hFF.
REQ-036 B4 data 00,00,00,BD then CA reads -> 16x 8'hFF; second 16 reads (page 190) -> INIT0, INIT1, 00...
REQ-037 Close frame after 1 of 3 CA operands, reopen, read 8'h73 -> 8'h00, state CMD.
REQ-038 nRES pulse low during ack -> ack and wb_dat_o 0 immediately; cfg_en=0; CA reads afterwards 8'hFF.
